// File: rtl/mem_map_pkg.sv
// Address map, timer control bit positions and region decode shared by the
// data memory bus and its timer.
package mem_map_pkg;

   localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
   localparam logic [31:0] PERIPH_BASE = 32'h0000_0400;

   // Word offsets inside the peripheral window
   localparam logic [2:0] OFF_LED    = 3'd0;
   localparam logic [2:0] OFF_SW     = 3'd1;
   localparam logic [2:0] OFF_TCOUNT = 3'd2;
   localparam logic [2:0] OFF_TCMP   = 3'd3;
   localparam logic [2:0] OFF_TCTRL  = 3'd4;
   localparam logic [2:0] OFF_TSTAT  = 3'd5;

   localparam int TCTRL_EN = 0;
   localparam int TCTRL_AR = 1;
   localparam int TCTRL_IE = 2;

   typedef enum logic [1:0] {
      REGION_RAM    = 2'd0,
      REGION_PERIPH = 2'd1,
      REGION_NONE   = 2'd2
   } region_e;

   // Takes the word address (byte address bits [31:2]).
   function automatic region_e decode_region(input logic [29:0] waddr);
      region_e r;
      if (waddr[29:8] == RAM_BASE[31:10]) begin
         r = REGION_RAM;
      end else if ((waddr[29:3] == PERIPH_BASE[31:5]) && (waddr[2:0] <= OFF_TSTAT)) begin
         r = REGION_PERIPH;
      end else begin
         r = REGION_NONE;
      end
      return r;
   endfunction

endpackage

// File: rtl/data_mem_bus_timer_unit.sv
// Free-running compare timer: TCOUNT/TCMP/TCTRL/TSTAT registers with
// optional auto-reload and a level interrupt.
module timer_unit
   import mem_map_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [2:0]  sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [31:0] tcount_q, tcount_d;
   logic [31:0] tcmp_q, tcmp_d;
   logic [2:0]  tctrl_q, tctrl_d;
   logic        tstat_q, tstat_d;
   logic        match;

   // Next-state and read-mux for the timer registers
   always_comb begin
      match    = tctrl_q[TCTRL_EN] && (tcount_q == tcmp_q);
      tcount_d = tcount_q;
      tcmp_d   = tcmp_q;
      tctrl_d  = tctrl_q;
      tstat_d  = tstat_q;
      rdata    = 32'd0;

      // A processor write wins over counting and reload
      if (we && (sel == OFF_TCOUNT)) begin
         tcount_d = wdata;
      end else if (match && tctrl_q[TCTRL_AR]) begin
         tcount_d = 32'd0;
      end else if (tctrl_q[TCTRL_EN]) begin
         tcount_d = tcount_q + 32'd1;
      end else begin
         tcount_d = tcount_q;
      end

      if (we && (sel == OFF_TCMP)) begin
         tcmp_d = wdata;
      end else begin
         tcmp_d = tcmp_q;
      end

      if (we && (sel == OFF_TCTRL)) begin
         tctrl_d = wdata[2:0];
      end else begin
         tctrl_d = tctrl_q;
      end

      // A new match beats a simultaneous write-one-to-clear
      if (match) begin
         tstat_d = 1'b1;
      end else if (we && (sel == OFF_TSTAT) && wdata[0]) begin
         tstat_d = 1'b0;
      end else begin
         tstat_d = tstat_q;
      end

      case (sel)
         OFF_TCOUNT: rdata = tcount_q;
         OFF_TCMP:   rdata = tcmp_q;
         OFF_TCTRL:  rdata = {29'd0, tctrl_q};
         OFF_TSTAT:  rdata = {31'd0, tstat_q};
         default:    rdata = 32'd0;
      endcase
   end

   // Timer register state
   always_ff @(posedge clk) begin
      if (reset) begin
         tcount_q <= 32'd0;
         tcmp_q   <= 32'd0;
         tctrl_q  <= 3'd0;
         tstat_q  <= 1'b0;
      end else begin
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         tctrl_q  <= tctrl_d;
         tstat_q  <= tstat_d;
      end
   end

   assign irq = tstat_q & tctrl_q[TCTRL_IE];

endmodule

// File: rtl/data_mem_bus.sv
// Processor data-side bus: word RAM, LED and switch registers, timer and an
// unmapped-access error pulse.
module data_mem_bus
   import mem_map_pkg::*;
#(
   parameter int RAM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WriteEnableMem,
   input  logic [31:0] AddressDataMem,
   input  logic [31:0] WriteDataMem,
   output logic [31:0] ReadData,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam int IDX_W = $clog2(RAM_WORDS);

   logic [31:0]      ram [RAM_WORDS];
   region_e          region;
   logic [2:0]       sel;
   logic [IDX_W-1:0] ram_idx;
   logic             periph_we;
   logic [31:0]      timer_rdata;
   logic [15:0]      led_q, led_d;
   logic [15:0]      sw_meta_q, sw_sync_q;
   logic             bus_err_q, bus_err_d;
   logic             addr_unused;

   assign addr_unused = ^AddressDataMem[1:0];

   // Address decode, LED next state, error detect and read mux
   always_comb begin
      region    = decode_region(AddressDataMem[31:2]);
      sel       = AddressDataMem[4:2];
      ram_idx   = AddressDataMem[IDX_W+1:2];
      periph_we = WriteEnableMem && (region == REGION_PERIPH);
      bus_err_d = (region == REGION_NONE);
      ReadData  = 32'd0;

      if (periph_we && (sel == OFF_LED)) begin
         led_d = WriteDataMem[15:0];
      end else begin
         led_d = led_q;
      end

      case (region)
         REGION_RAM: ReadData = ram[ram_idx];
         REGION_PERIPH: begin
            case (sel)
               OFF_LED: ReadData = {16'd0, led_q};
               OFF_SW:  ReadData = {16'd0, sw_sync_q};
               default: ReadData = timer_rdata;
            endcase
         end
         default: ReadData = 32'd0;
      endcase
   end

   // RAM store port; contents survive reset
   always_ff @(posedge clk) begin
      if (!reset && WriteEnableMem && (region == REGION_RAM)) begin
         ram[ram_idx] <= WriteDataMem;
      end
   end

   // LED register, switch synchronizer and bus error flop
   always_ff @(posedge clk) begin
      if (reset) begin
         led_q     <= 16'd0;
         sw_meta_q <= 16'd0;
         sw_sync_q <= 16'd0;
         bus_err_q <= 1'b0;
      end else begin
         led_q     <= led_d;
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
         bus_err_q <= bus_err_d;
      end
   end

   timer_unit u_timer (
      .clk   (clk),
      .reset (reset),
      .we    (periph_we),
      .sel   (sel),
      .wdata (WriteDataMem),
      .rdata (timer_rdata),
      .irq   (timer_irq)
   );

   assign led_out = led_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// Scoreboard bench for data_mem_bus: stimulus queues expectations, a
// negedge monitor drains and compares them.
module tb_data_mem_bus;

   localparam int K_RD  = 0;
   localparam int K_LED = 1;
   localparam int K_IRQ = 2;
   localparam int K_BUS = 3;
   localparam logic [31:0] IDLE = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        WriteEnableMem;
   logic [31:0] AddressDataMem;
   logic [31:0] WriteDataMem;
   logic [31:0] ReadData;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic        timer_irq;
   logic        bus_err;

   int          checks;
   int          errors;
   logic        chk;
   logic        done;
   int          kind_q[$];
   logic [31:0] exp_q[$];
   string       name_q[$];

   data_mem_bus dut (
      .clk            (clk),
      .reset          (reset),
      .WriteEnableMem (WriteEnableMem),
      .AddressDataMem (AddressDataMem),
      .WriteDataMem   (WriteDataMem),
      .ReadData       (ReadData),
      .sw_in          (sw_in),
      .led_out        (led_out),
      .timer_irq      (timer_irq),
      .bus_err        (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on every flagged cycle, compare all queued expectations
   always @(negedge clk) begin
      int          k;
      logic [31:0] e;
      logic [31:0] act;
      string       n;
      if (chk) begin
         while (exp_q.size() > 0) begin
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            case (k)
               K_RD:    act = ReadData;
               K_LED:   act = {16'd0, led_out};
               K_IRQ:   act = {31'd0, timer_irq};
               default: act = {31'd0, bus_err};
            endcase
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h", n, act, e);
            end
         end
      end
   end

   // Watchdog: the stimulus sequence must finish within a bounded time
   initial begin
      #100000;
      if (!done) begin
         errors++;
         $display("FAIL timeout: stimulus did not complete");
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   task automatic expect_out(input int k, input string n, input logic [31:0] e);
      kind_q.push_back(k);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic rd(input string n, input logic [31:0] a, input logic [31:0] e);
      AddressDataMem = a;
      expect_out(K_RD, n, e);
   endtask

   task automatic tick();
      chk = 1'b1;
      @(posedge clk);
      #1;
      chk = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      AddressDataMem = a;
      WriteDataMem   = d;
      WriteEnableMem = 1'b1;
      @(posedge clk);
      #1;
      WriteEnableMem = 1'b0;
      AddressDataMem = IDLE;
      WriteDataMem   = 32'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      chk = 1'b0;
      done = 1'b0;
      reset = 1'b1;
      WriteEnableMem = 1'b0;
      AddressDataMem = IDLE;
      WriteDataMem = 32'd0;
      sw_in = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state, checked directly
      checks++;
      if ((led_out !== 16'd0) || (timer_irq !== 1'b0) || (bus_err !== 1'b0)) begin
         errors++;
         $display("FAIL rst_direct: led_out=%h timer_irq=%b bus_err=%b", led_out, timer_irq, bus_err);
      end

      // Reset state
      expect_out(K_LED, "rst_led", 32'd0);
      expect_out(K_IRQ, "rst_irq", 32'd0);
      expect_out(K_BUS, "rst_bus_err", 32'd0);
      rd("rst_tcount", 32'h408, 32'd0);
      tick();

      // RAM store/load, byte offset ignored, neighbour untouched
      wr(32'h000, 32'h0BAD_C0DE);
      wr(32'h014, 32'h1111_1111);
      wr(32'h010, 32'hDEAD_BEEF);
      rd("ram_010", 32'h010, 32'hDEAD_BEEF);
      tick();
      rd("ram_013", 32'h013, 32'hDEAD_BEEF);
      tick();
      rd("ram_014", 32'h014, 32'h1111_1111);
      tick();

      // LED register
      wr(32'h400, 32'h0001_A5A5);
      expect_out(K_LED, "led_out", 32'h0000_A5A5);
      rd("led_read", 32'h400, 32'h0000_A5A5);
      tick();

      // Switch synchronizer: two edges of latency
      sw_in = 16'h00F0;
      rd("sw_edge0", 32'h404, 32'd0);
      tick();
      rd("sw_edge1", 32'h404, 32'd0);
      tick();
      rd("sw_edge2", 32'h404, 32'h0000_00F0);
      tick();
      wr(32'h404, 32'hFFFF_FFFF);
      rd("sw_ro", 32'h404, 32'h0000_00F0);
      tick();

      // Timer match with auto-reload and irq
      wr(32'h40C, 32'd5);
      wr(32'h410, 32'h7);
      repeat (5) @(posedge clk);
      #1;
      rd("tcount_5", 32'h408, 32'd5);
      expect_out(K_IRQ, "irq_before", 32'd0);
      tick();
      rd("tcount_reload", 32'h408, 32'd0);
      expect_out(K_IRQ, "irq_set", 32'd1);
      tick();
      rd("tstat_set", 32'h414, 32'd1);
      tick();
      wr(32'h414, 32'd1);
      rd("tstat_clr", 32'h414, 32'd0);
      expect_out(K_IRQ, "irq_clr", 32'd0);
      tick();
      wr(32'h410, 32'hFFFF_FFF8);
      rd("tctrl_upper", 32'h410, 32'd0);
      tick();

      // Unmapped store: one-cycle error pulse, no side effects
      wr(32'h800, 32'hCAFE_F00D);
      expect_out(K_BUS, "bus_err_pulse", 32'd1);
      tick();
      expect_out(K_BUS, "bus_err_end", 32'd0);
      rd("ram_000_kept", 32'h000, 32'h0BAD_C0DE);
      tick();
      rd("led_kept", 32'h400, 32'h0000_A5A5);
      tick();
      rd("unmapped_rd", 32'h800, 32'd0);
      tick();
      AddressDataMem = IDLE;
      expect_out(K_BUS, "bus_err_rd", 32'd1);
      tick();
      rd("gap_418", 32'h418, 32'd0);
      tick();
      AddressDataMem = IDLE;
      expect_out(K_BUS, "bus_err_418", 32'd1);
      tick();

      // Reset mid-count with a store during reset
      wr(32'h40C, 32'd100);
      wr(32'h408, 32'd0);
      wr(32'h410, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rd("tcount_2", 32'h408, 32'd2);
      tick();
      reset = 1'b1;
      WriteEnableMem = 1'b1;
      AddressDataMem = 32'h010;
      WriteDataMem = 32'd0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      WriteEnableMem = 1'b0;
      rd("ram_after_rst", 32'h010, 32'hDEAD_BEEF);
      expect_out(K_LED, "led_after_rst", 32'd0);
      expect_out(K_IRQ, "irq_after_rst", 32'd0);
      expect_out(K_BUS, "bus_after_rst", 32'd0);
      tick();
      rd("tcount_after_rst", 32'h408, 32'd0);
      tick();
      rd("tcmp_after_rst", 32'h40C, 32'd0);
      tick();
      rd("tctrl_after_rst", 32'h410, 32'd0);
      tick();
      rd("tstat_after_rst", 32'h414, 32'd0);
      tick();
      rd("ledreg_after_rst", 32'h400, 32'd0);
      tick();

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_bus.md
DATA_MEM_BUS -- requirements
Module: data_mem_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning the number of 32-bit data RAM words (power of two, at most 256).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port WriteEnableMem, input, 1 bit: processor store strobe.
REQ-005 SHALL have port AddressDataMem, input, 32 bits: processor byte address (the ALU result).
REQ-006 SHALL have port WriteDataMem, input, 32 bits: store data.
REQ-007 SHALL have port ReadData, output, 32 bits: load data, combinational from the address.
REQ-008 SHALL have port sw_in, input, 16 bits: asynchronous board switches.
REQ-009 SHALL have port led_out, output, 16 bits: LED register contents.
REQ-010 SHALL have port timer_irq, output, 1 bit: timer interrupt level.
REQ-011 SHALL have port bus_err, output, 1 bit: one-cycle pulse on an unmapped access.

Function
REQ-012 SHALL decode word address = AddressDataMem[31:2], ignoring bits [1:0].
REQ-013 SHALL map 0x000-0x3FF to RAM; RAM index = addr[9:2] mod RAM_WORDS; write is synchronous when WriteEnableMem=1; read is combinational.
REQ-014 SHALL map 0x400 LED (R/W, bits[15:0]; upper bits read 0); led_out = LED register.
REQ-015 SHALL map 0x404 SW (read-only): sw_in through a 2-flop synchronizer, zero-extended; writes ignored.
REQ-016 SHALL map 0x408 TCOUNT (R/W), 0x40C TCMP (R/W), 0x410 TCTRL (bit0 enable, bit1 auto-reload, bit2 irq-enable; others read 0), 0x414 TSTAT (bit0 match flag; write 1 to clear).
REQ-017 SHALL read any other address as 0x00000000, ignore writes to it, and assert bus_err for the cycle after the access when WriteEnableMem=1 or the address is unmapped during a read.
REQ-018 SHALL treat a read as any cycle, so bus_err for unmapped reads follows the address combinationally and is registered one cycle later.
REQ-019 SHALL increment TCOUNT by 1 each cycle while enable=1, wrapping from 0xFFFFFFFF to 0.
REQ-020 SHALL set the match flag on the edge following a cycle where enable=1 and TCOUNT==TCMP; with auto-reload=1, TCOUNT SHALL load 0 on that edge instead of incrementing.
REQ-021 SHALL give a processor write to TCOUNT priority over increment or reload in the same cycle.
REQ-022 SHALL give a match-flag set priority over a simultaneous W1C clear.
REQ-023 SHALL drive timer_irq = match flag AND irq-enable (combinational from registers).
REQ-024 SHALL return on a read of TCOUNT the pre-edge value in the same cycle.

Reset
REQ-025 SHALL set LED, TCOUNT, TCMP, TCTRL, TSTAT, the synchronizer flops and the bus_err flop to 0 on reset; led_out=0, timer_irq=0, bus_err=0 the cycle after reset.
REQ-026 SHALL NOT reset RAM contents; stores during reset SHALL be ignored.
REQ-027 SHALL give reset priority over every simultaneous write, increment, or match.

Structure
REQ-028 SHALL take address-map constants (region bases, register offsets) and TCTRL bit indices from a shared package mem_map_pkg.
REQ-029 SHALL implement TCOUNT/TCMP/TCTRL/TSTAT in one sub-module timer_unit; the RAM, LED, SW and decode SHALL stay at top level.

Verification
REQ-030 SHALL cover: store 0xDEADBEEF to 0x010, then load 0x010 and 0x013 -> both read 0xDEADBEEF; a load from 0x014 is unaffected.
REQ-031 SHALL cover: store 0x0001A5A5 to 0x400 -> led_out=0xA5A5; a read of 0x400 returns 0x0000A5A5.
REQ-032 SHALL cover: sw_in=0x00F0 -> a read of 0x404 returns 0x000000F0 two edges later, not before.
REQ-033 SHALL cover: TCMP=5, TCTRL=0x7 -> TSTAT[0]=1 and timer_irq=1 after TCOUNT reaches 5; TCOUNT reads 0 next; a write of 1 to 0x414 on a non-match cycle clears the irq.
REQ-034 SHALL cover: store to 0x800 -> bus_err pulses for exactly one cycle; RAM and registers unchanged; reads of 0x800 return 0.
REQ-035 SHALL cover: reset asserted mid-count with TCOUNT=3 -> all registers 0 next edge; RAM word at 0x010 retains 0xDEADBEEF.
